// File: rtl/mux8way16_arbiter_if.sv
// Purpose : handshake/bus bundle between producer lanes, the arbiter and the
//           downstream consumer.
// Signals : req       - per-lane "word ready" flags
//           in_data   - lane i word at in_data[i*WIDTH +: WIDTH]
//           out_ready - consumer accepts out_data this cycle
//           gnt       - one-hot registered grant
//           sel       - binary index of the granted lane (mux select)
//           out_valid - out_data holds a valid word
//           out_data  - latched word of the granted lane
//           ack       - per-lane transfer acknowledge
// Modports: slave  - arbiter side
//           master - producer/consumer side (testbench)
interface mux8way16_arbiter_if #(
    parameter int WIDTH = 16
);
    logic [7:0]         req;
    logic [8*WIDTH-1:0] in_data;
    logic               out_ready;
    logic [7:0]         gnt;
    logic [2:0]         sel;
    logic               out_valid;
    logic [WIDTH-1:0]   out_data;
    logic [7:0]         ack;

    modport slave (
        input  req, in_data, out_ready,
        output gnt, sel, out_valid, out_data, ack
    );

    modport master (
        output req, in_data, out_ready,
        input  gnt, sel, out_valid, out_data, ack
    );
endinterface

// File: rtl/mux8way16_arbiter.sv
// Purpose : round-robin arbiter/sequencer sharing one WIDTH-bit output bus
//           among 8 requesters. Grants one lane, latches its word and offers
//           it downstream with a valid/ready handshake.
// Ports   : clk    - system clock, rising edge
//           reset  - synchronous, active-high
//           bus    - mux8way16_arbiter_if.slave (req/in_data/out_ready in,
//                    gnt/sel/out_valid/out_data/ack out)
//           lock_i - per-lane burst lock (only with ARB_LOCK_EN)
// Option  : define ARB_LOCK_EN to add lock_i; a locked lane that still
//           requests in the arbitration cycle right after its transfer wins
//           again without advancing the rotation pointer.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | no word held; arbitrate among req and latch the winner
// BUSY  | word held on out_data, out_valid=1, waiting for out_ready
module mux8way16_arbiter #(
    parameter int WIDTH = 16
) (
    input  logic                clk,
    input  logic                reset,
`ifdef ARB_LOCK_EN
    input  logic [7:0]          lock_i,
`endif
    mux8way16_arbiter_if.slave  bus
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [2:0]         last_q, last_d;
    logic [2:0]         sel_q, sel_d;
    logic [7:0]         gnt_q, gnt_d;
    logic               out_valid_q, out_valid_d;
    logic [WIDTH-1:0]   out_data_q, out_data_d;
    logic               after_xfer_q, after_xfer_d;

    logic [2:0]         win;
    logic               win_found;
    logic [2:0]         idx;

    // Scan last+1, last+2, ... (3-bit arithmetic wraps 7 -> 0).
    always_comb begin
        win       = 3'd0;
        win_found = 1'b0;
        idx       = 3'd0;
        for (int k = 0; k < 8; k++) begin
            idx = last_q + 3'(k + 1);
            if (!win_found && bus.req[idx]) begin
                win_found = 1'b1;
                win       = idx;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        last_d       = last_q;
        sel_d        = sel_q;
        gnt_d        = gnt_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        after_xfer_d = 1'b0;

        case (state_q)
            IDLE: begin
                gnt_d       = 8'h00;
                out_valid_d = 1'b0;
`ifdef ARB_LOCK_EN
                // Lock only holds for the single cycle following a transfer
                // and only while the locked lane keeps requesting.
                if (after_xfer_q && lock_i[sel_q] && bus.req[sel_q]) begin
                    gnt_d       = 8'h01 << sel_q;
                    out_data_d  = bus.in_data[sel_q*WIDTH +: WIDTH];
                    out_valid_d = 1'b1;
                    state_d     = BUSY;
                end else
`endif
                if (win_found) begin
                    sel_d       = win;
                    gnt_d       = 8'h01 << win;
                    out_data_d  = bus.in_data[win*WIDTH +: WIDTH];
                    out_valid_d = 1'b1;
                    last_d      = win;
                    state_d     = BUSY;
                end
            end
            BUSY: begin
                if (bus.out_ready) begin
                    out_valid_d  = 1'b0;
                    gnt_d        = 8'h00;
                    after_xfer_d = 1'b1;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            last_q       <= 3'd7;
            sel_q        <= 3'd0;
            gnt_q        <= 8'h00;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            after_xfer_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_q       <= last_d;
            sel_q        <= sel_d;
            gnt_q        <= gnt_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            after_xfer_q <= after_xfer_d;
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.sel       = sel_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    // Gated by reset so a word dropped by a mid-transfer reset is never acked.
    assign bus.ack       = gnt_q & {8{out_valid_q & bus.out_ready & ~reset}};

endmodule

// File: tb/tb_mux8way16_arbiter.sv
module tb_mux8way16_arbiter;
    localparam int WIDTH = 16;

    logic clk = 1'b0;
    logic reset;
`ifdef ARB_LOCK_EN
    logic [7:0] lock;
`endif
    int n_total = 0;
    int n_bad   = 0;

    mux8way16_arbiter_if #(.WIDTH(WIDTH)) bus ();

    mux8way16_arbiter #(.WIDTH(WIDTH)) dut (
        .clk    (clk),
        .reset  (reset),
`ifdef ARB_LOCK_EN
        .lock_i (lock),
`endif
        .bus    (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Inputs change at the negedge; outputs are checked at the following negedge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_lane(input int i, input logic [WIDTH-1:0] v);
        bus.in_data[i*WIDTH +: WIDTH] = v;
    endtask

    task automatic expect_grant(input string tag, input int lane, input logic [WIDTH-1:0] d);
        check({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
        check({tag, "_sel"},   32'(bus.sel),       32'(lane));
        check({tag, "_gnt"},   32'(bus.gnt),       32'(8'h01 << lane));
        check({tag, "_data"},  32'(bus.out_data),  32'(d));
    endtask

    initial begin
        reset         = 1'b1;
        bus.req       = 8'h00;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
`ifdef ARB_LOCK_EN
        lock          = 8'h00;
`endif
        @(negedge clk);
        tick();
        bus.req = 8'h01;
        bus.out_ready = 1'b1;
        #1;
        check("rst_ack", 32'(bus.ack), 32'h0);
        bus.req = 8'h00;
        reset = 1'b0;
        check("rst_gnt",   32'(bus.gnt),       32'h0);
        check("rst_sel",   32'(bus.sel),       32'h0);
        check("rst_valid", 32'(bus.out_valid), 32'h0);
        check("rst_data",  32'(bus.out_data),  32'h0);

        // 1: single requester
        set_lane(0, 16'h0003);
        bus.req = 8'h01;
        tick();
        expect_grant("t1", 0, 16'h0003);
        check("t1_ack", 32'(bus.ack), 32'h01);
        bus.req = 8'h00;
        tick();
        check("t1_valid_off", 32'(bus.out_valid), 32'h0);
        check("t1_gnt_off",   32'(bus.gnt),       32'h0);

        // 2: full rotation from reset (last=7), one grant every 2 cycles
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 8; i++) set_lane(i, 16'(i * 9));
        bus.req = 8'hFF;
        for (int j = 0; j < 9; j++) begin
            tick();
            expect_grant($sformatf("t2_%0d", j), j % 8, 16'((j % 8) * 9));
            check($sformatf("t2_ack_%0d", j), 32'(bus.ack), 32'(8'h01 << (j % 8)));
            tick();
            check($sformatf("t2_gap_%0d", j), 32'(bus.out_valid), 32'h0);
        end
        bus.req = 8'h00;
        tick();

        // 3: backpressure on lane 2 (last=0)
        bus.out_ready = 1'b0;
        set_lane(2, 16'h0011);
        bus.req = 8'h04;
        tick();
        expect_grant("t3", 2, 16'h0011);
        check("t3_ack0", 32'(bus.ack), 32'h0);
        set_lane(2, 16'h0022);
        for (int j = 0; j < 5; j++) begin
            tick();
            expect_grant($sformatf("t3_hold%0d", j), 2, 16'h0011);
            check($sformatf("t3_ack_hold%0d", j), 32'(bus.ack), 32'h0);
        end
        bus.out_ready = 1'b1;
        #1;
        check("t3_ack", 32'(bus.ack), 32'h04);
        bus.req = 8'h00;
        tick();
        check("t3_valid_off", 32'(bus.out_valid), 32'h0);

        // 4: wrap-around between lanes 7 and 0
        set_lane(0, 16'h00A0);
        set_lane(7, 16'h00A7);
        bus.req = 8'h01;
        tick();
        expect_grant("t4_l0", 0, 16'h00A0);
        bus.req = 8'h81;
        tick();
        check("t4_idle", 32'(bus.out_valid), 32'h0);
        tick();
        expect_grant("t4_a", 7, 16'h00A7);
        tick();
        tick();
        expect_grant("t4_b", 0, 16'h00A0);
        tick();
        tick();
        expect_grant("t4_c", 7, 16'h00A7);
        bus.req = 8'h00;
        tick();

        // 5: reset while BUSY on lane 5
        bus.out_ready = 1'b0;
        set_lane(5, 16'h0055);
        bus.req = 8'h20;
        tick();
        expect_grant("t5", 5, 16'h0055);
        reset = 1'b1;
        bus.out_ready = 1'b1;
        #1;
        check("t5_ack_rst", 32'(bus.ack), 32'h0);
        tick();
        check("t5_gnt",   32'(bus.gnt),       32'h0);
        check("t5_sel",   32'(bus.sel),       32'h0);
        check("t5_valid", 32'(bus.out_valid), 32'h0);
        check("t5_data",  32'(bus.out_data),  32'h0);
        check("t5_ack",   32'(bus.ack),       32'h0);
        reset = 1'b0;
        set_lane(2, 16'h0202);
        set_lane(3, 16'h0303);
        bus.req = 8'h0C;
        tick();
        expect_grant("t5_after", 2, 16'h0202);
        bus.req = 8'h00;
        tick();

`ifdef ARB_LOCK_EN
        // 6: lane 3 locked (last=2 going in)
        set_lane(4, 16'h0404);
        lock = 8'h08;
        bus.req = 8'h18;
        for (int j = 0; j < 3; j++) begin
            tick();
            expect_grant($sformatf("t6_lock%0d", j), 3, 16'h0303);
            if (j == 2) lock = 8'h00;
            tick();
        end
        tick();
        expect_grant("t6_unlock", 4, 16'h0404);
        bus.req = 8'h00;
        tick();
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, bound expired");
        $fatal(1);
    end
endmodule
